pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): NSTAGE, 6, pipeline stages controlled (pc, if, id, ex, ls, wb).
REQ-002 SHALL have NSTALL, 3, stall requesters.
REQ-003 SHALL have NFLUSH, 3, flush requesters.
REQ-004 SHALL have AW, 32, redirect address width.
REQ-005 SHALL have STALL_DEPTH, {8'd3,8'd4,8'd3} packed NSTALL x 8, stages held per requester [excp, ex, id].
REQ-006 SHALL have FLUSH_MASK, {4'b0001,4'b0011,4'b0001} packed NFLUSH x (NSTAGE-2), pipeline registers flushed per requester.
REQ-007 SHALL have TMO_W, 8, stall watchdog counter width.
REQ-008 SHALL have ports (name, direction, width, meaning): clk, in, 1, sole clock.
REQ-009 SHALL have rst, in, 1, synchronous active-high reset.
REQ-010 SHALL have stallreq_i, in, NSTALL, level stall requests.
REQ-011 SHALL have flushreq_i, in, NFLUSH, single-cycle flush requests; bit 0 highest priority.
REQ-012 SHALL have flush_pc_i, in, NFLUSH*AW, redirect target per flush source.
REQ-013 SHALL have stall_o, out, NSTAGE, bit k holds stage k.
REQ-014 SHALL have flush_o, out, NSTAGE-2, bit j clears pipeline register j (if_id=0).
REQ-015 SHALL have redirect_valid_o, out, 1, redirect pending to ifu.
REQ-016 SHALL have redirect_pc_o, out, AW, redirect target.
REQ-017 SHALL have redirect_ready_i, in, 1, ifu accepts redirect.
REQ-018 SHALL have stall_tmo_o, out, 1, sticky watchdog flag.

Function
REQ-019 stall_o[k] SHALL be combinational: 1 if any stallreq_i[i]=1 with k < STALL_DEPTH[i], OR-ed over i.
REQ-020 flush_o SHALL be combinational: OR of FLUSH_MASK[j] over asserted flushreq_i[j], zero-latency.
REQ-021 Flush and stall in the same cycle: flush_o SHALL still assert; stall_o unchanged.
REQ-022 FSM SHALL have states IDLE and REDIR.
REQ-023 In IDLE, any flushreq_i SHALL capture flush_pc_i of lowest-index asserted source into redirect_pc_o and move to REDIR next cycle.
REQ-024 In REDIR, redirect_valid_o=1 and redirect_pc_o SHALL be stable until redirect_ready_i=1.
REQ-025 In REDIR, stall_o[1:0] SHALL be forced to 1 in addition to REQ-019.
REQ-026 In REDIR with redirect_ready_i=1 and no flushreq_i, the FSM SHALL return to IDLE next cycle.
REQ-027 In REDIR, a new flushreq_i SHALL overwrite redirect_pc_o next cycle and the FSM SHALL stay in REDIR, regardless of redirect_ready_i; the old target is dropped if not accepted that cycle.
REQ-028 The stall counter SHALL increment each cycle stall_o != 0, clear when stall_o == 0, and saturate at 2^TMO_W-1.
REQ-029 stall_tmo_o SHALL set the cycle after the counter reaches saturation and hold until rst.
REQ-030 Flush cycles SHALL NOT clear the stall counter.
REQ-031 Out-of-range STALL_DEPTH (>NSTAGE) SHALL clamp to NSTAGE.

Reset
REQ-032 On rst=1 at a clk edge, the FSM SHALL enter IDLE, with redirect_valid_o=0, redirect_pc_o=0, counter=0, stall_tmo_o=0.
REQ-033 During rst, stall_o and flush_o SHALL follow REQ-019/020 with the REDIR term inactive.
REQ-034 Reset asserted in REDIR SHALL drop the pending redirect without handshake.

Structure
REQ-035 Stage index constants (STG_PC..STG_WB) and FSM state encoding SHALL reside in shared package pipe_pkg.
REQ-036 Sub-module stall_wdog (counter plus sticky flag, parameter TMO_W) SHALL be instantiated once.
REQ-037 Default parameters SHALL reproduce current 6-stage stall/flush encodings exactly.

Verification
REQ-038 stallreq_i=3'b010 -> stall_o=6'b001111; stallreq_i=3'b001 -> 6'b000111; 3'b000 -> 0.
REQ-039 flushreq_i=3'b011, pcs 0x100/0x200 -> flush_o=4'b0011 same cycle; next cycle redirect_valid_o=1, redirect_pc_o=0x100, stall_o[1:0]=2'b11.
REQ-040 REDIR with ready low 3 cycles -> redirect_pc_o stable; ready high -> IDLE next cycle, valid=0.
REQ-041 REDIR with flushreq_i[2] pc=0x300 while ready=1 -> redirect_pc_o=0x300, valid remains 1.
REQ-042 TMO_W=4, stallreq_i held 16 cycles -> stall_tmo_o=1 on cycle 17, stays 1 after stall drops, clears only on rst.
REQ-043 rst pulse during REDIR -> redirect_valid_o=0 next cycle, stall_o[1:0] follows requests only.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared stage indices, redirect FSM encoding and helpers for the pipeline controller.
package pipe_pkg;

    localparam int unsigned STG_PC = 0;
    localparam int unsigned STG_IF = 1;
    localparam int unsigned STG_ID = 2;
    localparam int unsigned STG_EX = 3;
    localparam int unsigned STG_LS = 4;
    localparam int unsigned STG_WB = 5;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StRedir = 1'b1
    } redir_state_e;

    function automatic int unsigned clamp_depth(input int unsigned depth,
                                                input int unsigned nstage);
        return (depth > nstage) ? nstage : depth;
    endfunction

endpackage

// File: rtl/stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky timeout flag.
module stall_wdog
    import pipe_pkg::*;
#(
    parameter int unsigned TMO_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic tmo
);

    localparam logic [TMO_W-1:0] CntMax = '1;

    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    always_comb begin
        cnt_d = '0;
        if (stall) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end
        // Flag follows one cycle after the counter sits at its ceiling.
        tmo_d = tmo_q | (cnt_q == CntMax);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo = tmo_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: decodes stall/flush requests per stage and tracks a
// pending fetch redirect until the IFU accepts it.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned                  NSTAGE      = 6,
    parameter int unsigned                  NSTALL      = 3,
    parameter int unsigned                  NFLUSH      = 3,
    parameter int unsigned                  AW          = 32,
    parameter logic [NSTALL*8-1:0]          STALL_DEPTH = {8'd3, 8'd4, 8'd3},
    parameter logic [NFLUSH*(NSTAGE-2)-1:0] FLUSH_MASK  = {4'b0001, 4'b0011, 4'b0001},
    parameter int unsigned                  TMO_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSTALL-1:0]    stallreq_i,
    input  logic [NFLUSH-1:0]    flushreq_i,
    input  logic [NFLUSH*AW-1:0] flush_pc_i,
    output logic [NSTAGE-1:0]    stall_o,
    output logic [NSTAGE-3:0]    flush_o,
    output logic                 redirect_valid_o,
    output logic [AW-1:0]        redirect_pc_o,
    input  logic                 redirect_ready_i,
    output logic                 stall_tmo_o
);

    redir_state_e state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] sel_pc;
    logic          sel_found;
    logic          redir_force;

    // A redirect still pending while reset is asserted must not hold the front end.
    assign redir_force = (state_q == StRedir) && !rst;

    always_comb begin
        stall_o = '0;
        for (int unsigned i = 0; i < NSTALL; i++) begin
            if (stallreq_i[i]) begin
                for (int unsigned k = 0; k < NSTAGE; k++) begin
                    if (k < clamp_depth(32'(STALL_DEPTH[i*8 +: 8]), NSTAGE)) begin
                        stall_o[k] = 1'b1;
                    end
                end
            end
        end
        if (redir_force) begin
            stall_o[STG_PC] = 1'b1;
            stall_o[STG_IF] = 1'b1;
        end
    end

    always_comb begin
        flush_o = '0;
        for (int unsigned j = 0; j < NFLUSH; j++) begin
            if (flushreq_i[j]) begin
                flush_o = flush_o | FLUSH_MASK[j*(NSTAGE-2) +: (NSTAGE-2)];
            end
        end
    end

    // Lowest-index flush source wins the redirect target.
    always_comb begin
        sel_pc    = '0;
        sel_found = 1'b0;
        for (int unsigned j = 0; j < NFLUSH; j++) begin
            if (flushreq_i[j] && !sel_found) begin
                sel_pc    = flush_pc_i[j*AW +: AW];
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d = StRedir;
                    pc_d    = sel_pc;
                end
            end
            StRedir: begin
                if (sel_found) begin
                    pc_d = sel_pc;
                end else if (redirect_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign redirect_valid_o = (state_q == StRedir);
    assign redirect_pc_o    = pc_q;

    stall_wdog #(
        .TMO_W(TMO_W)
    ) u_stall_wdog (
        .clk  (clk),
        .rst  (rst),
        .stall(|stall_o),
        .tmo  (stall_tmo_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver pushes model predictions, a monitor compares.
module tb_pipe_ctrl;

    localparam int unsigned NSTAGE = 6;
    localparam int unsigned NSTALL = 3;
    localparam int unsigned NFLUSH = 3;
    localparam int unsigned AW     = 32;
    localparam int unsigned TMO_W  = 4;
    localparam int          CNT_MAX = (1 << TMO_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NSTALL-1:0]    stallreq;
    logic [NFLUSH-1:0]    flushreq;
    logic [NFLUSH*AW-1:0] flush_pc;
    logic [NSTAGE-1:0]    stall_o;
    logic [NSTAGE-3:0]    flush_o;
    logic                 redirect_valid;
    logic [AW-1:0]        redirect_pc;
    logic                 ready;
    logic                 stall_tmo;

    // Requester 2 is deliberately out of range to exercise depth clamping.
    pipe_ctrl #(
        .NSTAGE     (NSTAGE),
        .NSTALL     (NSTALL),
        .NFLUSH     (NFLUSH),
        .AW         (AW),
        .STALL_DEPTH({8'd200, 8'd4, 8'd3}),
        .FLUSH_MASK ({4'b0001, 4'b0011, 4'b0001}),
        .TMO_W      (TMO_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_i      (stallreq),
        .flushreq_i      (flushreq),
        .flush_pc_i      (flush_pc),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_valid_o(redirect_valid),
        .redirect_pc_o   (redirect_pc),
        .redirect_ready_i(ready),
        .stall_tmo_o     (stall_tmo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  stall;
        logic [3:0]  flush;
        logic        valid;
        logic [31:0] pc;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int unsigned depth_m[3] = '{3, 4, 200};
    logic [3:0]  mask_m[3]  = '{4'b0001, 4'b0011, 4'b0001};

    // Reference state: pending redirect, its target, stalled-cycle run length, timeout.
    logic        m_pending = 1'b0;
    logic [31:0] m_target  = '0;
    int          m_cnt     = 0;
    logic        m_tmo     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] s, input logic [2:0] f,
                        input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                        input logic rdy);
        exp_t        e;
        int unsigned d;
        logic [5:0]  st;
        logic [3:0]  fl;
        logic [31:0] pcs[3];
        logic        found;
        @(posedge clk);
        #1;
        rst      = r;
        stallreq = s;
        flushreq = f;
        flush_pc = {p2, p1, p0};
        ready    = rdy;
        pcs      = '{p0, p1, p2};

        st = '0;
        for (int i = 0; i < 3; i++) begin
            if (s[i]) begin
                d  = (depth_m[i] > NSTAGE) ? NSTAGE : depth_m[i];
                st = st | 6'((1 << d) - 1);
            end
        end
        if (m_pending && !r) st = st | 6'b000011;
        fl = '0;
        for (int i = 0; i < 3; i++) if (f[i]) fl = fl | mask_m[i];

        e.stall = st;
        e.flush = fl;
        e.valid = m_pending;
        e.pc    = m_target;
        e.tmo   = m_tmo;
        exp_q.push_back(e);

        if (r) begin
            m_pending = 1'b0;
            m_target  = '0;
            m_cnt     = 0;
            m_tmo     = 1'b0;
        end else begin
            if (m_cnt == CNT_MAX) m_tmo = 1'b1;
            if (st != 0) m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
            else m_cnt = 0;
            found = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (f[i] && !found) begin
                    m_target = pcs[i];
                    found    = 1'b1;
                end
            end
            if (found) m_pending = 1'b1;
            else if (m_pending && rdy) m_pending = 1'b0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall_o", 32'(stall_o), 32'(e.stall));
                check("flush_o", 32'(flush_o), 32'(e.flush));
                check("redirect_valid", 32'(redirect_valid), 32'(e.valid));
                check("redirect_pc", redirect_pc, e.pc);
                check("stall_tmo", 32'(stall_tmo), 32'(e.tmo));
            end
        end
    end

    initial begin : time_guard
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst      = 1'b1;
        stallreq = '0;
        flushreq = '0;
        flush_pc = '0;
        ready    = 1'b0;
        repeat (2) @(posedge clk);

        step(1, 3'b010, 0, 0, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0, 0, 0);
        step(0, 3'b010, 0, 0, 0, 0, 0);
        step(0, 3'b001, 0, 0, 0, 0, 0);
        step(0, 3'b100, 0, 0, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0, 0, 0);

        // Two-source flush, held redirect, then acceptance.
        step(0, 3'b000, 3'b011, 32'h100, 32'h200, 32'h0, 0);
        repeat (3) step(0, 3'b000, 0, 0, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0, 0, 1);
        step(0, 3'b000, 0, 0, 0, 0, 1);

        // Overwrite in REDIR while ready is high, plus flush alongside stall.
        step(0, 3'b000, 3'b001, 32'h500, 0, 0, 0);
        step(0, 3'b010, 3'b100, 0, 0, 32'h300, 1);
        step(0, 3'b000, 0, 0, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0, 0, 1);
        step(0, 3'b000, 0, 0, 0, 0, 0);

        // Reset while a redirect is pending.
        step(0, 3'b000, 3'b010, 0, 32'h700, 0, 0);
        step(1, 3'b001, 0, 0, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0, 0, 0);

        // Watchdog: 16 stalled cycles, drop stall, then reset clears the flag.
        repeat (16) step(0, 3'b100, 0, 0, 0, 0, 0);
        repeat (3) step(0, 3'b000, 0, 0, 0, 0, 0);
        step(1, 3'b000, 0, 0, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                 ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                 $urandom, $urandom, $urandom,
                 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
